pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised successor to the fixed five-field ID/EX pipeline register: a generic inter-stage register carrying FIELDS words of WIDTH bits, with valid/ready flow control, a 2-entry skid buffer, synchronous flush (bubble insertion) and a saturating stall counter. It is used for every pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Downstream stalls back-pressure upstream without a combinational ready path across stages.

## Interface
- WIDTH, 32, bits per field
- FIELDS, 5, number of fields packed into the data bus (field k at bits [k*WIDTH +: WIDTH])
- CNT_W, 16, stall counter width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- flush  in  1  synchronous clear to bubble (replaces old clr)
- in_valid  in  1  upstream has data
- in_ready  out  1  stage can accept; registered, depends only on state
- in_data  in  FIELDS*WIDTH  upstream payload
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  downstream accepts
- out_data  out  FIELDS*WIDTH  payload from main register
- occupancy  out  2  entries held, 0..2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register, each with a valid bit.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid). in_ready = (state != FULL).
- EMPTY: in_fire -> ONE, main <= in_data.
- ONE:
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire & !out_fire -> FULL, skid <= in_data.
  - !in_fire & out_fire -> EMPTY, main <= 0.
  - Otherwise hold.
- FULL: out_fire -> ONE, main <= skid, skid <= 0. Otherwise hold. in_valid is ignored.
- Invalid registers hold all-zero data, so a bubble is instruction 0x00000000 (sll $0,$0,0 = nop). out_data = 0 whenever out_valid = 0.
- Flush: next state EMPTY, both data registers zeroed. An in_fire or out_fire in the same cycle is discarded; no skid entry survives.
- Priority: reset > flush > normal operation.
- stall_cnt: +1 each cycle with out_valid & !out_ready, saturates at 2^CNT_W-1. Cleared only by reset; flush does not clear it.
- Unused state encoding (2'd3) returns to EMPTY with data zeroed.

## Timing
- Reset values: out_valid 0, out_data 0, in_ready 1, occupancy 0, stall_cnt 0; skid data 0. The flop contents after power-up are also defined by the same values.
- Latency: data accepted at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle when out_ready is held high; the skid never fills.
- in_ready drops the cycle after the skid fills and rises the cycle after FULL drains. in_ready has no combinational path from out_ready.
- out_data/out_valid change only on clk edges and are stable while out_valid & !out_ready (hold rule).
- Reset or flush asserted mid-transfer: effective at that edge. in_ready=1 and out_valid=0 in the following cycle.

## Structure
- Shared package pipe_pkg:
  - state constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - BUBBLE constant (32'h0).
  - Default WIDTH/FIELDS for ID/EX (5 fields: instr, pc4, rs, rt, ext).
- One sub-module: sat_counter (parameter CNT_W; ports clk, reset, inc, count), instantiated for stall_cnt.
- Field packing/unpacking stays in the instantiating stage top, not in this block.

## Test plan
- Reset then stream: in_valid=1, in_data fields 0x1..0x5 incrementing each cycle, out_ready=1 → out_data equals input one cycle later, occupancy stays 1, in_ready stays 1, stall_cnt=0.
- Back-pressure: one entry A is held (ONE). Drop out_ready for 3 cycles while presenting B, C → B taken into skid; in_ready=0 from the next cycle; C held upstream; out_data=A steady; stall_cnt=3. Raise out_ready → order A, B, C, no loss or duplicate.
- Flush in FULL with simultaneous in_valid=1, out_ready=1 → next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; neither the input nor the skid entry ever appears.
- Reset during FULL with stall_cnt=7 → all outputs return to reset values next cycle, stall_cnt=0.
- Saturation with CNT_W=3: hold out_valid=1, out_ready=0 for 10 cycles → stall_cnt reaches 7 and stays 7; flush does not clear it.
- Parameter sweep: WIDTH=8, FIELDS=1 and WIDTH=32, FIELDS=8 with random valid/ready → scoreboard shows in-order, lossless delivery with zero data whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// state encoding, bubble word and the ID/EX default geometry.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ONE    = 2'd1,
        ST_FULL   = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    // A bubble is instruction word zero: sll $0,$0,0, the architectural nop.
    localparam logic [31:0] BUBBLE = 32'h0;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_FIELDS = 5;
    localparam int DEF_CNT_W  = 16;

    // Field slots of the ID/EX boundary, field k at bits [k*WIDTH +: WIDTH].
    typedef enum int {
        F_INSTR = 0,
        F_PC4   = 1,
        F_RS    = 2,
        F_RT    = 3,
        F_EXT   = 4
    } idex_field_e;

    function automatic logic [1:0] occupancy_of(input state_t s);
        logic [1:0] occ;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q = '0;

    assign count = count_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline boundary register: main + skid entry, registered in_ready,
// synchronous flush to bubble and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FIELDS = DEF_FIELDS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FIELDS*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FIELDS*WIDTH-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int DW = FIELDS * WIDTH;
    localparam logic [DW-1:0] BUBBLE_BUS = DW'(BUBBLE);

    // Power-up contents match the reset values.
    state_t        state   = ST_EMPTY;
    logic [DW-1:0] main_q  = BUBBLE_BUS;
    logic [DW-1:0] skid_q  = BUBBLE_BUS;

    state_t        state_nx;
    logic [DW-1:0] main_nx;
    logic [DW-1:0] skid_nx;

    logic main_vld;
    logic in_fire;
    logic out_fire;

    assign main_vld = (state == ST_ONE) || (state == ST_FULL);

    // Decoded from the state register alone, so out_ready never reaches in_ready.
    // The unreachable encoding also refuses input, since it discards everything.
    assign in_ready  = (state == ST_EMPTY) || (state == ST_ONE);
    assign out_valid = main_vld;
    assign out_data  = main_vld ? main_q : BUBBLE_BUS;
    assign occupancy = occupancy_of(state);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_vld & out_ready;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;

        if (flush) begin
            state_nx = ST_EMPTY;
            main_nx  = BUBBLE_BUS;
            skid_nx  = BUBBLE_BUS;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nx = ST_ONE;
                        main_nx  = in_data;
                    end
                end

                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_nx = in_data;
                    end else if (in_fire) begin
                        state_nx = ST_FULL;
                        skid_nx  = in_data;
                    end else if (out_fire) begin
                        state_nx = ST_EMPTY;
                        main_nx  = BUBBLE_BUS;
                    end
                end

                ST_FULL: begin
                    if (out_fire) begin
                        state_nx = ST_ONE;
                        main_nx  = skid_q;
                        skid_nx  = BUBBLE_BUS;
                    end
                end

                default: begin
                    state_nx = ST_EMPTY;
                    main_nx  = BUBBLE_BUS;
                    skid_nx  = BUBBLE_BUS;
                end
            endcase
        end
    end

    // NOTE: the data registers are reset too, because a cleared entry must read as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_EMPTY;
            main_q <= BUBBLE_BUS;
            skid_q <= BUBBLE_BUS;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (main_vld & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, directed corner sequences,
// and randomized traffic on two extra geometries scored against a queue model.
module tb_pipe_stage_skid;

    localparam int W  = 32;
    localparam int F  = 5;
    localparam int DW = W * F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (CNT_W=16) and a CNT_W=3 twin share the same stimulus.
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, in_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          s3_out_valid, s3_in_ready;
    logic [DW-1:0] s3_out_data;
    logic [1:0]    s3_occupancy;
    logic [2:0]    s3_stall_cnt;

    // Random instance A: WIDTH=8, FIELDS=1.
    logic        ra_reset, ra_flush, ra_in_valid, ra_out_ready;
    logic [7:0]  ra_in_data, ra_out_data;
    logic        ra_out_valid, ra_in_ready;
    logic [1:0]  ra_occupancy;
    logic [15:0] ra_stall_cnt;

    // Random instance B: WIDTH=32, FIELDS=8.
    logic         rb_reset, rb_flush, rb_in_valid, rb_out_ready;
    logic [255:0] rb_in_data, rb_out_data;
    logic         rb_out_valid, rb_in_ready;
    logic [1:0]   rb_occupancy;
    logic [15:0]  rb_stall_cnt;

    pipe_stage_skid #(.WIDTH(W), .FIELDS(F), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.WIDTH(W), .FIELDS(F), .CNT_W(3)) dut_s3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s3_in_ready), .in_data(in_data),
        .out_valid(s3_out_valid), .out_ready(out_ready), .out_data(s3_out_data),
        .occupancy(s3_occupancy), .stall_cnt(s3_stall_cnt)
    );

    pipe_stage_skid #(.WIDTH(8), .FIELDS(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(ra_reset), .flush(ra_flush),
        .in_valid(ra_in_valid), .in_ready(ra_in_ready), .in_data(ra_in_data),
        .out_valid(ra_out_valid), .out_ready(ra_out_ready), .out_data(ra_out_data),
        .occupancy(ra_occupancy), .stall_cnt(ra_stall_cnt)
    );

    pipe_stage_skid #(.WIDTH(32), .FIELDS(8), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rb_reset), .flush(rb_flush),
        .in_valid(rb_in_valid), .in_ready(rb_in_ready), .in_data(rb_in_data),
        .out_valid(rb_out_valid), .out_ready(rb_out_ready), .out_data(rb_out_data),
        .occupancy(rb_occupancy), .stall_cnt(rb_stall_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [DW-1:0] d);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = d;
    endtask

    task automatic check_all(input string tag, input logic e_ov, input logic [DW-1:0] e_od,
                             input logic e_ir, input logic [1:0] e_occ, input logic [15:0] e_st);
        check($sformatf("%s.out_valid", tag), 256'(out_valid), 256'(e_ov));
        check($sformatf("%s.out_data",  tag), 256'(out_data),  256'(e_od));
        check($sformatf("%s.in_ready",  tag), 256'(in_ready),  256'(e_ir));
        check($sformatf("%s.occupancy", tag), 256'(occupancy), 256'(e_occ));
        check($sformatf("%s.stall_cnt", tag), 256'(stall_cnt), 256'(e_st));
    endtask

    // Payload whose field k holds b+k.
    function automatic logic [DW-1:0] mk(input int b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < F; k++) r[k*W +: W] = 32'(b + k);
        return r;
    endfunction

    typedef struct {
        logic          rst, fl, iv, ordy;
        logic [DW-1:0] d;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
        logic [1:0]    e_occ;
        logic [15:0]   e_st;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic fl, input logic iv, input logic ordy,
                                 input logic [DW-1:0] d, input logic e_ov, input logic [DW-1:0] e_od,
                                 input logic e_ir, input logic [1:0] e_occ, input logic [15:0] e_st);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ; v.e_st = e_st;
        return v;
    endfunction

    // Behavioural model: an in-order FIFO of at most two entries plus a stall tally.
    logic [255:0] qa[$];
    logic [255:0] qb[$];
    int unsigned  cnta, cntb;

    task automatic model_step(input int id, input logic rst, input logic fl, input logic iv,
                              input logic ordy, input logic [255:0] d);
        int          sz;
        int unsigned cnt;
        logic        can_take, has_out;
        sz       = (id == 0) ? qa.size() : qb.size();
        cnt      = (id == 0) ? cnta : cntb;
        can_take = (sz < 2);
        has_out  = (sz > 0);
        if (rst) begin
            cnt = 0;
            if (id == 0) qa.delete(); else qb.delete();
        end else begin
            if (has_out && !ordy && cnt < 65535) cnt++;
            if (fl) begin
                if (id == 0) qa.delete(); else qb.delete();
            end else begin
                if (has_out && ordy) begin
                    if (id == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                end
                if (iv && can_take) begin
                    if (id == 0) qa.push_back(d); else qb.push_back(d);
                end
            end
        end
        if (id == 0) cnta = cnt; else cntb = cnt;
    endtask

    vec_t tbl[7];

    initial begin
        logic [DW-1:0] ea, eb, ec, ed, ee, ef, eg, eh, ex;
        logic [255:0]  exp_d;

        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        ra_reset = 1'b1; ra_flush = 1'b0; ra_in_valid = 1'b0; ra_out_ready = 1'b0; ra_in_data = '0;
        rb_reset = 1'b1; rb_flush = 1'b0; rb_in_valid = 1'b0; rb_out_ready = 1'b0; rb_in_data = '0;

        // Reset, then a streaming run with out_ready held high, then drain and idle.
        tbl[0] = mkv(1'b1, 1'b0, 1'b0, 1'b0, '0,    1'b0, '0,    1'b1, 2'd0, 16'd0);
        tbl[1] = mkv(1'b0, 1'b0, 1'b1, 1'b1, mk(1), 1'b1, mk(1), 1'b1, 2'd1, 16'd0);
        tbl[2] = mkv(1'b0, 1'b0, 1'b1, 1'b1, mk(2), 1'b1, mk(2), 1'b1, 2'd1, 16'd0);
        tbl[3] = mkv(1'b0, 1'b0, 1'b1, 1'b1, mk(3), 1'b1, mk(3), 1'b1, 2'd1, 16'd0);
        tbl[4] = mkv(1'b0, 1'b0, 1'b1, 1'b1, mk(4), 1'b1, mk(4), 1'b1, 2'd1, 16'd0);
        tbl[5] = mkv(1'b0, 1'b0, 1'b0, 1'b1, '0,    1'b0, '0,    1'b1, 2'd0, 16'd0);
        tbl[6] = mkv(1'b0, 1'b0, 1'b0, 1'b0, '0,    1'b0, '0,    1'b1, 2'd0, 16'd0);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].d);
            tick();
            check_all($sformatf("tbl%0d", i), tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ir,
                      tbl[i].e_occ, tbl[i].e_st);
        end

        // Back-pressure: A held, B into skid, C waits upstream, then drain in order.
        ea = mk(32'hA00); eb = mk(32'hB00); ec = mk(32'hC00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, ea); tick(); check_all("bp_load_a", 1'b1, ea, 1'b1, 2'd1, 16'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, eb); tick(); check_all("bp_skid_b", 1'b1, ea, 1'b0, 2'd2, 16'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, ec); tick(); check_all("bp_hold1",  1'b1, ea, 1'b0, 2'd2, 16'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, ec); tick(); check_all("bp_hold2",  1'b1, ea, 1'b0, 2'd2, 16'd3);
        check("bp_s3_stall", 256'(s3_stall_cnt), 256'(3'd3));
        drive(1'b0, 1'b0, 1'b1, 1'b1, ec); tick(); check_all("bp_out_b",  1'b1, eb, 1'b1, 2'd1, 16'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, ec); tick(); check_all("bp_out_c",  1'b1, ec, 1'b1, 2'd1, 16'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0); tick(); check_all("bp_drain",  1'b0, '0, 1'b1, 2'd0, 16'd3);

        // Flush while FULL with a simultaneous transfer on both sides.
        ed = mk(32'hD00); ee = mk(32'hE00); ef = mk(32'hF00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, ed); tick(); check_all("fl_load_d", 1'b1, ed, 1'b1, 2'd1, 16'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0, ee); tick(); check_all("fl_full",   1'b1, ed, 1'b0, 2'd2, 16'd4);
        drive(1'b0, 1'b1, 1'b1, 1'b1, ef); tick(); check_all("fl_flush",  1'b0, '0, 1'b1, 2'd0, 16'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0); tick(); check_all("fl_after",  1'b0, '0, 1'b1, 2'd0, 16'd4);

        // Reset while FULL with stall_cnt at 7.
        eg = mk(32'h1100); eh = mk(32'h2200);
        drive(1'b0, 1'b0, 1'b1, 1'b0, eg); tick(); check_all("rs_load",   1'b1, eg, 1'b1, 2'd1, 16'd4);
        drive(1'b0, 1'b0, 1'b1, 1'b0, eh); tick(); check_all("rs_full",   1'b1, eg, 1'b0, 2'd2, 16'd5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0); tick(); check_all("rs_st7",    1'b1, eg, 1'b0, 2'd2, 16'd7);
        drive(1'b1, 1'b0, 1'b1, 1'b1, ef); tick(); check_all("rs_reset",  1'b0, '0, 1'b1, 2'd0, 16'd0);
        check("rs_s3_stall", 256'(s3_stall_cnt), 256'(3'd0));

        // Saturation of the 3-bit counter; flush leaves it alone.
        ex = mk(32'h3300);
        drive(1'b0, 1'b0, 1'b1, 1'b0, ex); tick(); check_all("sat_load", 1'b1, ex, 1'b1, 2'd1, 16'd0);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            tick();
            check($sformatf("sat%0d.s3_stall", i), 256'(s3_stall_cnt), 256'((i > 7) ? 7 : i));
            check($sformatf("sat%0d.stall", i), 256'(stall_cnt), 256'(i));
            check($sformatf("sat%0d.s3_data", i), 256'(s3_out_data), 256'(ex));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0); tick();
        check("sat_flush.s3_stall", 256'(s3_stall_cnt), 256'(3'd7));
        check("sat_flush.s3_valid", 256'(s3_out_valid), 256'(1'b0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
        check("sat_idle.s3_stall", 256'(s3_stall_cnt), 256'(3'd7));
        check_all("sat_idle", 1'b0, '0, 1'b1, 2'd0, 16'd11);

        // Randomized traffic on the two sweep geometries.
        qa.delete(); qb.delete(); cnta = 0; cntb = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            ra_reset     = (cyc == 0) || ($urandom_range(0, 199) == 0);
            ra_flush     = ($urandom_range(0, 31) == 0);
            ra_in_valid  = ($urandom_range(0, 3) != 0);
            ra_out_ready = ($urandom_range(0, 2) != 0);
            ra_in_data   = 8'($urandom);
            rb_reset     = (cyc == 0) || ($urandom_range(0, 199) == 0);
            rb_flush     = ($urandom_range(0, 31) == 0);
            rb_in_valid  = ($urandom_range(0, 2) != 0);
            rb_out_ready = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 8; j++) rb_in_data[j*32 +: 32] = $urandom;
            model_step(0, ra_reset, ra_flush, ra_in_valid, ra_out_ready, 256'(ra_in_data));
            model_step(1, rb_reset, rb_flush, rb_in_valid, rb_out_ready, rb_in_data);
            tick();

            exp_d = (qa.size() > 0) ? qa[0] : '0;
            check($sformatf("ra%0d.out_valid", cyc), 256'(ra_out_valid), 256'(qa.size() > 0));
            check($sformatf("ra%0d.out_data",  cyc), 256'(ra_out_data),  exp_d);
            check($sformatf("ra%0d.in_ready",  cyc), 256'(ra_in_ready),  256'(qa.size() < 2));
            check($sformatf("ra%0d.occupancy", cyc), 256'(ra_occupancy), 256'(qa.size()));
            check($sformatf("ra%0d.stall_cnt", cyc), 256'(ra_stall_cnt), 256'(cnta));

            exp_d = (qb.size() > 0) ? qb[0] : '0;
            check($sformatf("rb%0d.out_valid", cyc), 256'(rb_out_valid), 256'(qb.size() > 0));
            check($sformatf("rb%0d.out_data",  cyc), rb_out_data,        exp_d);
            check($sformatf("rb%0d.in_ready",  cyc), 256'(rb_in_ready),  256'(qb.size() < 2));
            check($sformatf("rb%0d.occupancy", cyc), 256'(rb_occupancy), 256'(qb.size()));
            check($sformatf("rb%0d.stall_cnt", cyc), 256'(rb_stall_cnt), 256'(cntb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
